// File: rtl/nanosoc_input_hold.sv
// nanosoc_input_hold
// AHB input stage of the bus matrix. Passes a master's address phase straight
// through when the target output stage grants it in the same cycle, otherwise
// captures it into a hold register and stalls the master until it is granted.
// The data phase response of the owning output stage is routed back to the
// master.
// Optional: define NANOSOC_INPUT_HOLD_ERR_EN to answer transfers that decode to
// no output port locally with a two-cycle ERROR response.

module nanosoc_input_hold #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  input  logic                  decode_err,
  input  logic                  active_trans,
  input  logic                  readyout_m,
  input  logic                  resp_m,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic                  sel_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [1:0]            trans_out,
  output logic [7:0]            ctrl_out
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_DATA
`ifdef NANOSOC_INPUT_HOLD_ERR_EN
    ,
    ST_ERR1,
    ST_ERR2
`endif
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [1:0]            hold_trans;
  logic [7:0]            hold_ctrl;

  logic                  new_tran;
  logic                  err_hit;
  logic                  fwd;
  logic                  accept;
  logic [7:0]            ctrl_in;

  // NONSEQ/SEQ address phase accepted from the master this cycle
  assign new_tran = HSELS & HREADYS & HTRANSS[1];
  assign ctrl_in  = {HMASTLOCKS, HBURSTS, HSIZES, HWRITES};

`ifdef NANOSOC_INPUT_HOLD_ERR_EN
  assign err_hit = new_tran & decode_err;
`else
  // decode_err has no effect in this build; the AND keeps the port read
  assign err_hit = 1'b0 & decode_err;
`endif

  assign fwd = new_tran & ~err_hit;

  // States in which a new address phase may be taken from the master
  always_comb begin
    accept = 1'b0;
    case (state)
      ST_IDLE: accept = 1'b1;
      ST_DATA: accept = readyout_m;
`ifdef NANOSOC_INPUT_HOLD_ERR_EN
      ST_ERR2: accept = 1'b1;
`endif
      default: accept = 1'b0;
    endcase
  end

  // Transfer sequencing and hold register capture
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= ST_IDLE;
      hold_addr  <= '0;
      hold_trans <= '0;
      hold_ctrl  <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (active_trans) begin
            state      <= ST_DATA;
            hold_addr  <= '0;
            hold_trans <= '0;
            hold_ctrl  <= '0;
          end
        end
`ifdef NANOSOC_INPUT_HOLD_ERR_EN
        ST_ERR1: state <= ST_ERR2;
`endif
        default: begin
          if (accept) begin
            if (err_hit) begin
`ifdef NANOSOC_INPUT_HOLD_ERR_EN
              state <= ST_ERR1;
`endif
            end else if (new_tran && active_trans) begin
              state <= ST_DATA;
            end else if (new_tran) begin
              state      <= ST_HOLD;
              hold_addr  <= HADDRS;
              hold_trans <= HTRANSS;
              hold_ctrl  <= ctrl_in;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Master response and downstream request, selected by state
  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = 1'b0;
    sel_out    = fwd;
    addr_out   = HADDRS;
    trans_out  = fwd ? HTRANSS : 2'b00;
    ctrl_out   = ctrl_in;
    case (state)
      ST_HOLD: begin
        HREADYOUTS = 1'b0;
        sel_out    = 1'b1;
        addr_out   = hold_addr;
        trans_out  = hold_trans;
        ctrl_out   = hold_ctrl;
      end
      ST_DATA: begin
        HREADYOUTS = readyout_m;
        HRESPS     = resp_m;
      end
`ifdef NANOSOC_INPUT_HOLD_ERR_EN
      ST_ERR1: begin
        HREADYOUTS = 1'b0;
        HRESPS     = 1'b1;
      end
      ST_ERR2: begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nanosoc_input_hold.sv
// Scoreboard bench for nanosoc_input_hold: directed per-cycle vectors push
// their expected outputs; a monitor pops and compares on the falling edge.

module tb_nanosoc_input_hold;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSELS = 1'b0;
  logic [31:0] HADDRS = '0;
  logic [1:0]  HTRANSS = '0;
  logic        HWRITES = 1'b0;
  logic [2:0]  HSIZES = 3'b010;
  logic [2:0]  HBURSTS = '0;
  logic        HMASTLOCKS = 1'b0;
  logic        HREADYS = 1'b1;
  logic        decode_err = 1'b0;
  logic        active_trans = 1'b0;
  logic        readyout_m = 1'b1;
  logic        resp_m = 1'b0;
  logic        HREADYOUTS;
  logic        HRESPS;
  logic        sel_out;
  logic [31:0] addr_out;
  logic [1:0]  trans_out;
  logic [7:0]  ctrl_out;

  nanosoc_input_hold #(.ADDR_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .decode_err(decode_err),
    .active_trans(active_trans), .readyout_m(readyout_m), .resp_m(resp_m),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .sel_out(sel_out),
    .addr_out(addr_out), .trans_out(trans_out), .ctrl_out(ctrl_out)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string       nm;
    logic [44:0] exp;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad = 0;

  // {HREADYOUTS, HRESPS, sel_out, trans_out, ctrl_out, addr_out}
  function automatic logic [44:0] pack(input logic r, input logic e, input logic s,
                                       input logic [1:0] t, input logic [7:0] c,
                                       input logic [31:0] a);
    return {r, e, s, t, c, a};
  endfunction

  // monitor: compare every cycle that has an expectation queued
  initial begin
    sb_t         e;
    logic [44:0] act;
    forever begin
      @(negedge HCLK);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = pack(HREADYOUTS, HRESPS, sel_out, trans_out, ctrl_out, addr_out);
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got rdy=%b resp=%b sel=%b trans=%b ctrl=%h addr=%h, want rdy=%b resp=%b sel=%b trans=%b ctrl=%h addr=%h",
                   e.nm, act[44], act[43], act[42], act[41:40], act[39:32], act[31:0],
                   e.exp[44], e.exp[43], e.exp[42], e.exp[41:40], e.exp[39:32], e.exp[31:0]);
        end
      end
    end
  end

  // drive one cycle of inputs just after the rising edge and queue the expectation
  task automatic v(input logic rstn, input logic sel, input logic [31:0] addr,
                   input logic [1:0] trans, input logic [7:0] ctrl, input logic hrdy,
                   input logic derr, input logic act, input logic rdym, input logic respm,
                   input string nm, input logic er, input logic eresp, input logic esel,
                   input logic [1:0] etrans, input logic [7:0] ectrl, input logic [31:0] eaddr);
    sb_t e;
    @(posedge HCLK);
    #1;
    HRESETn      = rstn;
    HSELS        = sel;
    HADDRS       = addr;
    HTRANSS      = trans;
    HMASTLOCKS   = ctrl[7];
    HBURSTS      = ctrl[6:4];
    HSIZES       = ctrl[3:1];
    HWRITES      = ctrl[0];
    HREADYS      = hrdy;
    decode_err   = derr;
    active_trans = act;
    readyout_m   = rdym;
    resp_m       = respm;
    e.nm  = nm;
    e.exp = pack(er, eresp, esel, etrans, ectrl, eaddr);
    sb.push_back(e);
  endtask

  initial begin
    // reset and idle behaviour
    v(0, 0, 32'h0, 2'b00, 8'h04, 1, 0, 0, 1, 0, "reset",        1, 0, 0, 2'b00, 8'h04, 32'h0);
    v(1, 0, 32'h10, 2'b00, 8'h04, 1, 0, 0, 1, 0, "idle",        1, 0, 0, 2'b00, 8'h04, 32'h10);
    v(1, 1, 32'h14, 2'b01, 8'h04, 1, 0, 1, 1, 0, "busy_ignored", 1, 0, 0, 2'b00, 8'h04, 32'h14);
    // granted in the same cycle, two wait states in data phase
    v(1, 1, 32'h100, 2'b10, 8'h04, 1, 0, 1, 1, 0, "grant_same", 1, 0, 1, 2'b10, 8'h04, 32'h100);
    v(1, 0, 32'h104, 2'b00, 8'h04, 0, 0, 0, 0, 1, "data_wait1", 0, 1, 0, 2'b00, 8'h04, 32'h104);
    v(1, 0, 32'h104, 2'b00, 8'h04, 0, 0, 0, 0, 0, "data_wait2", 0, 0, 0, 2'b00, 8'h04, 32'h104);
    v(1, 0, 32'h104, 2'b00, 8'h04, 1, 0, 0, 1, 0, "data_done",  1, 0, 0, 2'b00, 8'h04, 32'h104);
    // not granted: held for three stalled cycles while the master bus changes
    v(1, 1, 32'h4000_0000, 2'b10, 8'h05, 1, 0, 0, 1, 0, "hold_req",   1, 0, 1, 2'b10, 8'h05, 32'h4000_0000);
    v(1, 1, 32'h5555_0000, 2'b11, 8'h04, 0, 0, 0, 1, 0, "hold1",      0, 0, 1, 2'b10, 8'h05, 32'h4000_0000);
    v(1, 0, 32'h6666_0000, 2'b00, 8'h04, 0, 0, 0, 1, 0, "hold2",      0, 0, 1, 2'b10, 8'h05, 32'h4000_0000);
    v(1, 1, 32'h7777_0000, 2'b10, 8'h04, 0, 0, 1, 1, 0, "hold_grant", 0, 0, 1, 2'b10, 8'h05, 32'h4000_0000);
    v(1, 0, 32'h80, 2'b00, 8'h04, 1, 0, 0, 1, 0, "hold_data",         1, 0, 0, 2'b00, 8'h04, 32'h80);
    // INCR4 burst, granted every beat, zero wait
    v(1, 1, 32'h1000, 2'b10, 8'h34, 1, 0, 1, 1, 0, "incr_b0", 1, 0, 1, 2'b10, 8'h34, 32'h1000);
    v(1, 1, 32'h1004, 2'b11, 8'h34, 1, 0, 1, 1, 0, "incr_b1", 1, 0, 1, 2'b11, 8'h34, 32'h1004);
    v(1, 1, 32'h1008, 2'b11, 8'h34, 1, 0, 1, 1, 0, "incr_b2", 1, 0, 1, 2'b11, 8'h34, 32'h1008);
    v(1, 1, 32'h100C, 2'b11, 8'h34, 1, 0, 1, 1, 0, "incr_b3", 1, 0, 1, 2'b11, 8'h34, 32'h100C);
    // data completes with a new ungranted transfer -> captured into hold
    v(1, 1, 32'h2000_0000, 2'b10, 8'h04, 1, 0, 0, 1, 0, "data_to_hold", 1, 0, 1, 2'b10, 8'h04, 32'h2000_0000);
    v(1, 0, 32'h0, 2'b00, 8'h04, 0, 0, 0, 1, 0, "in_hold",              0, 0, 1, 2'b10, 8'h04, 32'h2000_0000);
    // asynchronous reset while holding
    v(0, 1, 32'h2000_0000, 2'b10, 8'h04, 0, 0, 0, 1, 0, "reset_hold", 1, 0, 0, 2'b00, 8'h04, 32'h2000_0000);
    v(1, 0, 32'h0, 2'b00, 8'h04, 1, 0, 0, 1, 0, "post_reset",         1, 0, 0, 2'b00, 8'h04, 32'h0);
`ifdef NANOSOC_INPUT_HOLD_ERR_EN
    // unmapped address answered locally with two-cycle ERROR
    v(1, 1, 32'h9000_0000, 2'b10, 8'h04, 1, 1, 0, 1, 0, "derr_req", 1, 0, 0, 2'b00, 8'h04, 32'h9000_0000);
    v(1, 0, 32'h9000_0000, 2'b00, 8'h04, 0, 0, 0, 1, 0, "err1",     0, 1, 0, 2'b00, 8'h04, 32'h9000_0000);
    v(1, 0, 32'h9000_0000, 2'b00, 8'h04, 1, 0, 0, 1, 0, "err2",     1, 1, 0, 2'b00, 8'h04, 32'h9000_0000);
    v(1, 0, 32'h0, 2'b00, 8'h04, 1, 0, 0, 1, 0, "err_done",         1, 0, 0, 2'b00, 8'h04, 32'h0);
`else
    // decode_err has no effect: transfer forwarded normally
    v(1, 1, 32'h9000_0000, 2'b10, 8'h04, 1, 1, 1, 1, 0, "derr_ignored", 1, 0, 1, 2'b10, 8'h04, 32'h9000_0000);
    v(1, 0, 32'h94, 2'b00, 8'h04, 0, 0, 0, 0, 1, "derr_data",           0, 1, 0, 2'b00, 8'h04, 32'h94);
    v(1, 0, 32'h94, 2'b00, 8'h04, 1, 0, 0, 1, 0, "derr_done",           1, 0, 0, 2'b00, 8'h04, 32'h94);
`endif
    // let the monitor drain the queue, bounded
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge HCLK);
    #1;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nanosoc_input_hold.md
NANOSOC_INPUT_HOLD -- requirements
Module: nanosoc_input_hold

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-002 SHALL have port HCLK  input  1  AHB system clock; one clock, all state on rising edge.
REQ-003 SHALL have port HRESETn  input  1  AHB system reset; asynchronous, active-low.
REQ-004 SHALL have port HSELS  input  1  master-side select for this input port.
REQ-005 SHALL have port HADDRS  input  ADDR_WIDTH  master address.
REQ-006 SHALL have port HTRANSS  input  2  master transfer type.
REQ-007 SHALL have port HWRITES  input  1  master write flag.
REQ-008 SHALL have port HSIZES  input  3  master transfer size.
REQ-009 SHALL have port HBURSTS  input  3  master burst type.
REQ-010 SHALL have port HMASTLOCKS  input  1  master locked-transfer flag.
REQ-011 SHALL have port HREADYS  input  1  bus HREADY seen by the master; address phase sampled only when 1.
REQ-012 SHALL have port decode_err  input  1  current address maps to no output port.
REQ-013 SHALL have port active_trans  input  1  granted output stage takes this port's address phase this cycle.
REQ-014 SHALL have port readyout_m  input  1  HREADYOUT of output stage owning this port's data phase.
REQ-015 SHALL have port resp_m  input  1  HRESP of that output stage.
REQ-016 SHALL have port HREADYOUTS  output  1  ready returned to master.
REQ-017 SHALL have port HRESPS  output  1  response returned to master (0 OKAY, 1 ERROR).
REQ-018 SHALL have port sel_out  output  1  transfer request toward decoder/arbiters.
REQ-019 SHALL have port addr_out  output  ADDR_WIDTH  address presented downstream.
REQ-020 SHALL have port trans_out  output  2  transfer type presented downstream.
REQ-021 SHALL have port ctrl_out  output  8  {mastlock, burst[2:0], size[2:0], write} presented downstream.

Function
REQ-022 SHALL define new_tran = HSELS & HREADYS & HTRANSS[1] (NONSEQ or SEQ); IDLE/BUSY never requested or held.
REQ-023 SHALL implement FSM states IDLE, HOLD, DATA (plus ERR1, ERR2 under config).
REQ-024 SHALL, with no held transfer, pass master signals combinationally to addr_out/trans_out/ctrl_out; sel_out = new_tran.
REQ-025 SHALL, when new_tran & !active_trans at a clock edge, register HADDRS/HTRANSS/control into the hold register and enter HOLD.
REQ-026 SHALL, in HOLD, drive outputs from the hold register, sel_out=1, HREADYOUTS=0, HRESPS=0.
REQ-027 SHALL, when active_trans=1 (IDLE with new_tran, or HOLD), enter DATA at the next edge and clear the hold register; zero added latency when granted same cycle.
REQ-028 SHALL, in DATA, drive HREADYOUTS=readyout_m, HRESPS=resp_m; leave DATA when readyout_m=1.
REQ-029 SHALL, at DATA completion with a new transfer: active_trans=1 -> stay DATA; else -> HOLD with capture; no new_tran -> IDLE.
REQ-030 SHALL drive HREADYOUTS=1, HRESPS=0 in IDLE (IDLE/BUSY/unselected transfers get zero-wait OKAY).
REQ-031 SHALL keep the hold register stable while in HOLD regardless of master-side inputs (master is stalled by HREADYOUTS=0).
REQ-032 SHALL force trans_out=2'b00 and sel_out=0 whenever no transfer is pending or passing.

Reset
REQ-033 SHALL, on HRESETn low (any time, including mid-HOLD/DATA), go to IDLE, clear hold register and data-phase state; HREADYOUTS=1, HRESPS=0, sel_out=0, outputs reflect pass-through.
REQ-034 SHALL use no synchronous reset.

Configuration
REQ-035 SHALL, with NANOSOC_INPUT_HOLD_ERR_EN defined, answer new_tran with decode_err=1 locally: sel_out=0, enter ERR1 (HREADYOUTS=0, HRESPS=1), then ERR2 (HREADYOUTS=1, HRESPS=1), then IDLE/HOLD/DATA per new_tran.
REQ-036 SHALL, without NANOSOC_INPUT_HOLD_ERR_EN, ignore decode_err; ERR1/ERR2 absent and all transfers forwarded.

Verification
REQ-037 Reset mid-HOLD with HADDRS=0x2000_0000 -> next cycle HREADYOUTS=1, sel_out=0, trans_out=00.
REQ-038 NONSEQ to 0x0000_0100 with active_trans=1 same cycle -> no stall; DATA next cycle; HREADYOUTS follows readyout_m (two wait states -> two low cycles).
REQ-039 NONSEQ to 0x4000_0000, active_trans low 3 cycles -> HREADYOUTS=0 3 cycles, addr_out held 0x4000_0000 while HADDRS changes; grant -> DATA.
REQ-040 Back-to-back INCR4 SEQ beats, readyout_m=1, active_trans=1 each beat -> stays DATA, 4 zero-wait beats, trans_out 10,11,11,11.
REQ-041 With NANOSOC_INPUT_HOLD_ERR_EN, NONSEQ with decode_err=1 -> HRESPS=1 two cycles, HREADYOUTS 0 then 1, sel_out=0 throughout.
